// File: rtl/fpu_issue_queue.sv
// fpu_issue_queue: in-order operand-wait FIFO that snoops result buses and issues ready heads to the FPU.
package fpu_issue_queue_pkg;
  localparam int PHYS_W = 7;
  typedef struct packed {
    logic        valid;
    logic [31:0] content;
  } src_t;
  typedef struct packed {
    logic [4:0]        op;
    logic [PHYS_W-1:0] dest_phys;
    src_t              src1;
    src_t              src2;
  } fpu_instr_t;
  typedef struct packed {
    logic              kind;
    logic [PHYS_W-1:0] dest_phys;
    logic [31:0]       data;
  } result_t;
endpackage

module fpu_issue_queue
  import fpu_issue_queue_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int NUM_WAKE = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flash,
  input  logic                dispatch_en,
  input  fpu_instr_t          dispatch_msg,
  output logic                dispatch_reject,
  output logic                fpu_instr_en,
  output fpu_instr_t          fpu_instr_msg,
  input  logic                fpu_instr_reject,
  input  logic [NUM_WAKE-1:0] wake_en,
  input  result_t             wake [NUM_WAKE]
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] rd, wr;
  logic [AW-1:0] h, wi;
  logic [4:0] op_q [DEPTH];
  logic [PHYS_W-1:0] dest_q [DEPTH];
  logic [31:0] c1 [DEPTH];
  logic [31:0] c2 [DEPTH];
  logic [DEPTH-1:0] v1, v2;
  src_t w1 [DEPTH];
  src_t w2 [DEPTH];
  src_t e1, e2;
  logic empty, full, enq, deq;
  // Descending scan so the lowest-index matching bus has the final say.
  function automatic src_t snoop(input src_t s);
    snoop = s;
    for (int b = NUM_WAKE - 1; b >= 0; b--)
      if (!s.valid && wake_en[b] && !wake[b].kind && wake[b].dest_phys == s.content[PHYS_W-1:0])
        snoop = '{valid: 1'b1, content: wake[b].data};
  endfunction
  assign h = rd[AW-1:0];
  assign wi = wr[AW-1:0];
  assign empty = rd == wr;
  assign full = rd[AW-1:0] == wr[AW-1:0] && rd[AW] != wr[AW];
  assign dispatch_reject = full | reset | flash;
  assign fpu_instr_en = ~empty & v1[h] & v2[h] & ~reset & ~flash;
  assign fpu_instr_msg = {op_q[h], dest_q[h], v1[h], c1[h], v2[h], c2[h]};
  assign enq = dispatch_en & ~dispatch_reject;
  assign deq = fpu_instr_en & ~fpu_instr_reject;
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w1[i] = snoop(src_t'({v1[i], c1[i]}));
      w2[i] = snoop(src_t'({v2[i], c2[i]}));
    end
    e1 = snoop(dispatch_msg.src1);
    e2 = snoop(dispatch_msg.src2);
  end
  always_ff @(posedge clock) begin
    if (reset | flash) begin
      rd <= '0;
      wr <= '0;
      v1 <= '0;
      v2 <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        v1[i] <= w1[i].valid;
        c1[i] <= w1[i].content;
        v2[i] <= w2[i].valid;
        c2[i] <= w2[i].content;
      end
      if (enq) begin
        op_q[wi] <= dispatch_msg.op;
        dest_q[wi] <= dispatch_msg.dest_phys;
        v1[wi] <= e1.valid;
        c1[wi] <= e1.content;
        v2[wi] <= e2.valid;
        c2[wi] <= e2.content;
        wr <= wr + 1'b1;
      end
      if (deq) rd <= rd + 1'b1;
    end
  end
endmodule
